// File: rtl/burst_mem_responder_pkg.sv
// Shared definitions for the burst memory responder: FSM encoding and
// burst-size decoding.
package burst_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2
   } state_t;

   // A burst_size field of zero encodes the maximum burst length.
   localparam logic [5:0] MAX_BEATS = 6'd32;

   function automatic logic [5:0] decode_beats(input logic [4:0] size);
      return (size == 5'd0) ? MAX_BEATS : {1'b0, size};
   endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// Request/response bus between a burst requester and the memory responder.
interface burst_mem_responder_if;

   logic        rreq;
   logic        wreq;
   logic [31:0] addr;
   logic [4:0]  burst_size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        ack;
   logic        err;

   modport master (
      output rreq, wreq, addr, burst_size, wdata,
      input  rdata, busy, ack, err
   );

   modport slave (
      input  rreq, wreq, addr, burst_size, wdata,
      output rdata, busy, ack, err
   );

endinterface

// File: rtl/burst_mem_array.sv
// Single-port word RAM: synchronous write, combinational read.
module burst_mem_array #(
   parameter int unsigned DEPTH_LOG2 = 13
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_comb begin
      rdata = mem[addr];
   end

endmodule

// File: rtl/burst_mem_responder.sv
// Burst read/write responder serving a word-addressed window of local RAM
// with a fixed wait latency before the first beat.
module burst_mem_responder
   import burst_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned DEPTH_LOG2 = 13,
   parameter int unsigned LATENCY    = 2
) (
   input  logic            clk,
   input  logic            reset,
   burst_mem_responder_if.slave bus
);

   localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t                state_q, state_d;
   logic                  is_write_q;
   logic [DEPTH_LOG2-1:0] ptr_q;
   logic [5:0]            remaining_q;
   logic [3:0]            wait_q;
   logic                  err_q;
   logic [31:0]           rdata_q;

   logic [31:0]           offset;
   logic                  in_window;
   logic                  one_req;
   logic                  accept;
   logic                  reject;
   logic                  beat;
   logic                  mem_we;
   logic [31:0]           mem_rdata;

   always_comb begin
      offset    = bus.addr - BASE_ADDR;
      // Subtract first, then test the high bits, so the window end never overflows.
      in_window = (bus.addr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == '0);
      one_req   = bus.rreq ^ bus.wreq;
      accept    = (state_q == IDLE) && one_req && in_window;
      reject    = (state_q == IDLE) && (bus.rreq || bus.wreq) && !(one_req && in_window);
      beat      = (state_q == XFER);
      mem_we    = beat && is_write_q && !reset;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (LATENCY == 0) ? XFER : WAIT;
            end
         end
         WAIT: begin
            if (wait_q == 4'd0) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (remaining_q == 6'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         is_write_q  <= 1'b0;
         ptr_q       <= '0;
         remaining_q <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         err_q <= reject;
         if (accept) begin
            is_write_q  <= bus.wreq;
            ptr_q       <= offset[DEPTH_LOG2+1:2];
            remaining_q <= decode_beats(bus.burst_size);
            wait_q      <= WAIT_INIT;
         end
         if ((state_q == WAIT) && (wait_q != 4'd0)) begin
            wait_q <= wait_q - 4'd1;
         end
         if (beat) begin
            ptr_q       <= ptr_q + 1'b1;
            remaining_q <= remaining_q - 6'd1;
            rdata_q     <= mem_rdata;
         end
      end
   end

   burst_mem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (ptr_q),
      .wdata (bus.wdata),
      .rdata (mem_rdata)
   );

   // Read data is live during a beat and otherwise holds the last beat.
   always_comb begin
      bus.rdata = beat ? mem_rdata : rdata_q;
      bus.busy  = (state_q != IDLE);
      bus.ack   = beat;
      bus.err   = err_q;
   end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: stimulus queues expected beats,
// a negedge monitor pops and compares on every ack.
module tb_burst_mem_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   burst_mem_responder_if bus_a();
   burst_mem_responder_if bus_z();

   burst_mem_responder #(
      .BASE_ADDR (32'h0000_0000),
      .DEPTH_LOG2(13),
      .LATENCY   (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_a)
   );

   burst_mem_responder #(
      .BASE_ADDR (32'h0000_0000),
      .DEPTH_LOG2(13),
      .LATENCY   (0)
   ) dut_z (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_z)
   );

   typedef struct {
      bit          rd;
      logic [31:0] data;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       mon_b;
   logic [31:0] model [0:8191];
   logic [31:0] none_q[$];
   logic [31:0] d[$];
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus_a.ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=1 expected no beat at %0t", $time);
         end else begin
            mon_b = exp_q.pop_front();
            if (mon_b.rd) check("rdata_beat", bus_a.rdata, mon_b.data);
            else          check("wdata_beat", bus_a.wdata, mon_b.data);
         end
      end
   end

   // Burst on the LATENCY=2 responder; abort_after>0 asserts reset during that beat+1.
   task automatic burst(input bit rd, input logic [31:0] a, input logic [4:0] sz,
                        input logic [31:0] wd[$], input int unsigned abort_after, input string tag);
      int unsigned n;
      int unsigned base;
      int unsigned lim;
      int unsigned nb;
      int unsigned busy_cyc;
      int unsigned guard;
      int unsigned idx;
      bit          ack_s;
      n        = (sz == 5'd0) ? 32 : int'(sz);
      base     = int'(a[14:2]);
      lim      = (abort_after != 0) ? abort_after : n;
      nb       = 0;
      busy_cyc = 0;
      guard    = 0;
      for (int unsigned i = 0; i < lim; i++) begin
         idx = (base + i) % 8192;
         if (rd) exp_q.push_back('{1'b1, model[idx]});
         else begin
            exp_q.push_back('{1'b0, wd[i]});
            model[idx] = wd[i];
         end
      end
      @(posedge clk); #1;
      bus_a.rreq = rd; bus_a.wreq = !rd; bus_a.addr = a; bus_a.burst_size = sz;
      bus_a.wdata = rd ? 32'h0 : wd[0];
      @(posedge clk); #1;
      bus_a.rreq = 1'b0; bus_a.wreq = 1'b0;
      while (nb < n && guard < 100) begin
         guard++;
         @(negedge clk);
         ack_s = bus_a.ack;
         if (bus_a.busy) busy_cyc++;
         if (ack_s) nb++;
         @(posedge clk); #1;
         if (!rd && ack_s && nb < n) bus_a.wdata = wd[nb];
         if (abort_after != 0 && nb == abort_after) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            break;
         end
      end
      if (abort_after == 0 && nb != n) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d beats expected %0d", tag, nb, n);
      end
      if (abort_after == 0) check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(n + 2));
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(bus_a.busy), 32'd0);
      check({tag, "_ack_after"}, 32'(bus_a.ack), 32'd0);
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
      if (abort_after != 0) begin
         check({tag, "_rdata_reset"}, bus_a.rdata, 32'd0);
         check({tag, "_err_reset"}, 32'(bus_a.err), 32'd0);
      end else if (rd) begin
         check({tag, "_rdata_hold"}, bus_a.rdata, model[(base + n - 1) % 8192]);
      end
      @(posedge clk); #1;
   endtask

   task automatic reject(input bit rd, input bit wr, input logic [31:0] a, input string tag);
      @(posedge clk); #1;
      bus_a.rreq = rd; bus_a.wreq = wr; bus_a.addr = a; bus_a.burst_size = 5'd4;
      bus_a.wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus_a.rreq = 1'b0; bus_a.wreq = 1'b0;
      @(negedge clk);
      check({tag, "_err_pulse"}, 32'(bus_a.err), 32'd1);
      check({tag, "_busy_low"}, 32'(bus_a.busy), 32'd0);
      @(negedge clk);
      check({tag, "_err_gone"}, 32'(bus_a.err), 32'd0);
      check({tag, "_busy_still_low"}, 32'(bus_a.busy), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected completion by 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0]  seq;
      logic        err_seen;
      logic        busy_s;
      for (int i = 0; i < 8192; i++) model[i] = 32'h0;
      reset = 1'b1;
      bus_a.rreq = 1'b0; bus_a.wreq = 1'b0; bus_a.addr = '0; bus_a.burst_size = '0; bus_a.wdata = '0;
      bus_z.rreq = 1'b0; bus_z.wreq = 1'b0; bus_z.addr = '0; bus_z.burst_size = '0; bus_z.wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(bus_a.busy), 32'd0);
      check("reset_ack", 32'(bus_a.ack), 32'd0);
      check("reset_err", 32'(bus_a.err), 32'd0);
      check("reset_rdata", bus_a.rdata, 32'd0);

      d.delete();
      for (int i = 1; i <= 8; i++) d.push_back(32'(i));
      burst(1'b0, 32'h100, 5'd8, d, 0, "wr8");
      burst(1'b1, 32'h100, 5'd8, none_q, 0, "rd8");

      d.delete();
      for (int i = 0; i < 32; i++) d.push_back(32'h1000 + 32'(i));
      burst(1'b0, 32'h0, 5'd0, d, 0, "wr32");
      burst(1'b1, 32'h0, 5'd0, none_q, 0, "rd32");

      d.delete();
      for (int i = 1; i <= 4; i++) d.push_back(32'hA000_0000 + 32'(i));
      burst(1'b0, 32'h7FFC, 5'd4, d, 0, "wr_wrap");
      burst(1'b1, 32'h7FFC, 5'd1, none_q, 0, "rd_last_word");
      burst(1'b1, 32'h0, 5'd3, none_q, 0, "rd_wrapped_words");
      burst(1'b1, 32'h7FFC, 5'd4, none_q, 0, "rd_wrap");

      reject(1'b1, 1'b1, 32'h100, "both_req");
      reject(1'b1, 1'b0, 32'h10000, "out_of_window");
      reject(1'b0, 1'b1, 32'h10000, "out_of_window_wr");
      burst(1'b1, 32'h100, 5'd8, none_q, 0, "rd8_after_reject");

      d.delete();
      for (int i = 0; i < 8; i++) d.push_back(32'h0000_00A0 + 32'(i));
      burst(1'b0, 32'h200, 5'd8, d, 0, "wr_pre_abort");
      d.delete();
      for (int i = 0; i < 8; i++) d.push_back(32'h0000_00B0 + 32'(i));
      burst(1'b0, 32'h200, 5'd8, d, 3, "wr_abort");
      burst(1'b1, 32'h200, 5'd8, none_q, 0, "rd_after_abort");

      // Zero-latency responder: a request held high while busy waits for IDLE.
      err_seen = 1'b0;
      @(posedge clk); #1;
      bus_z.rreq = 1'b1; bus_z.addr = 32'h20; bus_z.burst_size = 5'd4;
      @(posedge clk); #1;
      bus_z.addr = 32'h40; bus_z.burst_size = 5'd2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seq[9 - i] = bus_z.ack;
         busy_s     = bus_z.busy;
         if (bus_z.err) err_seen = 1'b1;
         @(posedge clk); #1;
         if (!busy_s && bus_z.rreq) bus_z.rreq = 1'b0;
      end
      check("lat0_first_ack", 32'(seq[9]), 32'd1);
      check("lat0_ack_sequence", 32'(seq), 32'(10'b1111011000));
      check("lat0_no_err_while_busy", 32'(err_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte base address of the served window.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 13, giving the window size of 2^DEPTH_LOG2 32-bit words.
REQ-003 The block SHALL have parameter LATENCY, default 2, range 0..15, giving the wait cycles before the first data beat.
REQ-004 The block SHALL have these ports: clk input 1, clock; reset input 1, synchronous active-high; all logic on rising clk.
REQ-005 The block SHALL have these ports: rreq input 1, burst read request; wreq input 1, burst write request; addr input 32, byte start address, bits [1:0] ignored.
REQ-006 The block SHALL have these ports: burst_size input 5, beat count (0 means 32); wdata input 32, write beat data.
REQ-007 The block SHALL have these ports: rdata output 32, read beat data; busy output 1, burst in progress; ack output 1, one beat transferred this cycle; err output 1, request rejected pulse.

Function
REQ-008 States SHALL be IDLE, WAIT, XFER.
REQ-009 In IDLE, a request SHALL be accepted at the edge where exactly one of rreq/wreq is high and the address is in the window [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2); busy SHALL be 1 from the next cycle.
REQ-010 On accept, the block SHALL latch the direction, word pointer = (addr - BASE_ADDR) >> 2, and remaining = burst_size (0 becomes 32).
REQ-011 After accept, the block SHALL go to WAIT for LATENCY cycles, or straight to XFER if LATENCY is 0.
REQ-012 In XFER, each cycle SHALL be one beat with ack=1.
REQ-013 On a read beat, rdata SHALL equal mem[pointer] in the same cycle ack is high.
REQ-014 On a write beat, wdata SHALL be written to mem[pointer] at the closing edge of that ack cycle; the requester advances wdata after each edge where ack is high.
REQ-015 On every beat, the pointer SHALL increment modulo 2^DEPTH_LOG2 and remaining SHALL decrement.
REQ-016 After the last beat, the block SHALL return to IDLE: busy=0 and ack=0 in the following cycle; the first beat of a new burst is therefore at least LATENCY+2 cycles after the last beat.
REQ-017 A request with both rreq and wreq high, or with an out-of-window address, SHALL be ignored, with err=1 for exactly one cycle and the state kept at IDLE.
REQ-018 Requests while busy=1 SHALL be ignored, without err.
REQ-019 rdata SHALL hold its last value when ack=0.
REQ-020 Burst latency SHALL be: first beat at accept edge + 1 + LATENCY cycles; total busy cycles = LATENCY + beats.

Reset
REQ-021 Reset SHALL force state=IDLE, busy=0, ack=0, err=0, rdata=0, pointer=0, remaining=0.
REQ-022 Reset mid-burst SHALL abort the burst; words already written SHALL remain, and no further writes SHALL occur.
REQ-023 Memory contents SHALL NOT be cleared by reset; simulation initialises them to 0.

Structure
REQ-024 The state encoding (IDLE=0, WAIT=1, XFER=2) and the burst_size-0→32 decode constant SHALL live in shared package burst_resp_pkg.
REQ-025 Storage SHALL be a single sub-module, burst_mem_array: one-port synchronous-write, combinational-read word RAM of 2^DEPTH_LOG2 x 32.
REQ-026 Beat counter and pointer SHALL be 6 and DEPTH_LOG2 bits wide.

Verification
REQ-027 Write 8 beats at addr 0x100 with data 1..8, LATENCY=2 -> busy for 10 cycles, 8 ack pulses, 8 words stored; then read 8 beats at 0x100 -> rdata 1..8 on consecutive ack cycles.
REQ-028 burst_size=0 read at 0x0 -> exactly 32 ack pulses, then busy=0.
REQ-029 Write 4 beats at the last word of the window (0x7FFC, DEPTH_LOG2=13) -> words land at indices 8191, 0, 1, 2.
REQ-030 rreq=wreq=1 in IDLE, and separately addr=0x10000 -> err pulse of one cycle, busy stays 0, memory unchanged.
REQ-031 Reset asserted after beat 3 of an 8-beat write -> busy=0 on the next cycle, words 0..2 written, words 3..7 unchanged.
REQ-032 LATENCY=0 read at 0x20 -> ack high the cycle directly after the accept edge; a second rreq raised while busy produces no err and is not served until IDLE.
